// File: rtl/decoder_scan.sv
// Registered one-hot decoder with enable blanking and an auto-scan mode.
// Scan mode holds each index for dwell+1 enabled cycles, then steps to the next index up to `last` and wraps back to 0.
module decoder_scan #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [SEL_W-1:0]        last,
  input  logic [DWELL_W-1:0]      dwell,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        idx,
  output logic                    wrap
);

  localparam int N = 1 << SEL_W;

  logic [SEL_W-1:0]   idx_q,  idx_d;
  logic [DWELL_W-1:0] cnt_q,  cnt_d;
  logic [N-1:0]       out_q,  out_d;
  logic               wrap_q, wrap_d;
  logic               mode_q, mode_d;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    out_d  = '0;
    wrap_d = 1'b0;
    mode_d = mode_q;
    if (en) begin
      mode_d = mode;
      if (!mode) begin
        idx_d = sel;
        cnt_d = '0;
        out_d = onehot(sel);
      end else if (!mode_q) begin
        // First dwell cycle of whichever index is currently held.
        cnt_d = '0;
        out_d = onehot(idx_q);
      end else if (cnt_q < dwell) begin
        // out is rebuilt from idx so that unblanking mid-dwell restores it.
        cnt_d = cnt_q + DWELL_W'(1);
        out_d = onehot(idx_q);
      end else begin
        cnt_d = '0;
        if (idx_q < last) begin
          idx_d = idx_q + SEL_W'(1);
          out_d = onehot(idx_q + SEL_W'(1));
        end else begin
          idx_d  = '0;
          out_d  = onehot('0);
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

  // out may only be blank or the decode of idx.
  a_out_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (out_q == '0) || (out_q == onehot(idx_q)));

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: directed scan sequences on a 4-line instance, a direct-decode table on a
// 16-line instance, and randomized traffic on the 16-line instance checked against a reference model.
module tb_decoder_scan;

  logic clk;
  logic rst_n;

  logic        en2, mode2;
  logic [1:0]  sel2, last2;
  logic [15:0] dwell2;
  logic [3:0]  out2;
  logic [1:0]  idx2;
  logic        wrap2;

  logic        en4, mode4;
  logic [3:0]  sel4, last4;
  logic [3:0]  dwell4;
  logic [15:0] out4;
  logic [3:0]  idx4;
  logic        wrap4;

  int n_checks;
  int n_errors;

  decoder_scan #(.SEL_W(2), .DWELL_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .sel(sel2), .last(last2),
    .dwell(dwell2), .out(out2), .idx(idx2), .wrap(wrap2)
  );

  decoder_scan #(.SEL_W(4), .DWELL_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .sel(sel4), .last(last4),
    .dwell(dwell4), .out(out4), .idx(idx4), .wrap(wrap4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check2(input string name, input int e_idx, input bit e_on, input bit e_wrap);
    logic [3:0] e_out;
    e_out = e_on ? 4'(1 << e_idx) : 4'd0;
    check({name, ".out"},  32'(out2),  32'(e_out));
    check({name, ".idx"},  32'(idx2),  32'(e_idx));
    check({name, ".wrap"}, 32'(wrap2), 32'(e_wrap));
  endtask

  // reference model for the 16-line instance: active index, dwell count, lit flag
  int m_idx, m_cnt;
  bit m_on, m_wrap, m_scanning;

  task automatic model_reset();
    m_idx = 0; m_cnt = 0; m_on = 0; m_wrap = 0; m_scanning = 0;
  endtask

  task automatic model_step(input bit e, input bit m, input int s, input int l, input int d);
    if (!e) begin
      m_on = 0;
      m_wrap = 0;
      return;
    end
    m_on = 1;
    m_wrap = 0;
    if (!m) begin
      m_idx = s;
      m_cnt = 0;
    end else if (!m_scanning) begin
      m_cnt = 0;
    end else if (m_cnt < d) begin
      m_cnt = m_cnt + 1;
    end else begin
      m_cnt = 0;
      if (m_idx >= l) begin
        m_idx = 0;
        m_wrap = 1;
      end else begin
        m_idx = m_idx + 1;
      end
    end
    m_scanning = m;
  endtask

  typedef struct {
    bit         en;
    bit         mode;
    logic [3:0] sel;
    logic [15:0] exp_out;
    logic [3:0] exp_idx;
    bit         exp_wrap;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    en2 = 0; mode2 = 0; sel2 = 0; last2 = 0; dwell2 = 0;
    en4 = 0; mode4 = 0; sel4 = 0; last4 = 0; dwell4 = 0;
    model_reset();

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check2("reset_idle", 0, 0, 0);

    // direct decode, then asynchronous reset mid-cycle
    en2 = 1; mode2 = 0; sel2 = 2;
    tick();
    check2("direct_sel2", 2, 1, 0);
    sel2 = 3;
    tick();
    check2("direct_sel3", 3, 1, 0);
    #3 rst_n = 1'b0;
    #1;
    check2("async_reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en2 = 0;
    tick();

    // scan wrap: dwell=3, last=3 from idx 0
    en2 = 1; mode2 = 1; dwell2 = 3; last2 = 3;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check2($sformatf("scan_wrap_e%0d", k), ((k - 1) / 4) % 4, 1, k == 17);
    end

    // short scan: last=1, dwell=0
    last2 = 1; dwell2 = 0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      check2($sformatf("short_scan_e%0d", j), j % 2, 1, (j % 2) == 0);
    end
    last2 = 0;
    tick();
    check2("last_lowered", 0, 1, 1);
    tick();
    check2("last_zero", 0, 1, 1);

    // freeze / resume at idx=2, cnt=1
    dwell2 = 3; last2 = 3;
    repeat (9) tick();
    check2("pre_freeze", 2, 1, 0);
    en2 = 0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check2($sformatf("frozen_e%0d", j), 2, 0, 0);
    end
    en2 = 1;
    tick();
    check2("resume_e1", 2, 1, 0);
    tick();
    check2("resume_e2", 2, 1, 0);
    tick();
    check2("resume_e3", 3, 1, 0);

    // mode switch: direct to idx 1, then scan restarts dwell there
    mode2 = 0; sel2 = 1;
    tick();
    check2("to_direct", 1, 1, 0);
    mode2 = 1; sel2 = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check2($sformatf("rescan_e%0d", k), (k == 5) ? 2 : 1, 1, 0);
    end
    en2 = 0;

    // table-driven direct decode on the 16-line instance
    for (int i = 0; i < 16; i++) begin
      v.en = 1; v.mode = 0; v.sel = 4'(i);
      v.exp_out = 16'(1 << i); v.exp_idx = 4'(i); v.exp_wrap = 0;
      vecs.push_back(v);
    end
    v = '{en: 0, mode: 0, sel: 4'd7, exp_out: 16'h0000, exp_idx: 4'd15, exp_wrap: 0}; vecs.push_back(v);
    v = '{en: 0, mode: 1, sel: 4'd7, exp_out: 16'h0000, exp_idx: 4'd15, exp_wrap: 0}; vecs.push_back(v);
    v = '{en: 1, mode: 0, sel: 4'd5, exp_out: 16'h0020, exp_idx: 4'd5,  exp_wrap: 0}; vecs.push_back(v);
    v = '{en: 1, mode: 1, sel: 4'd0, exp_out: 16'h0020, exp_idx: 4'd5,  exp_wrap: 0}; vecs.push_back(v);
    v = '{en: 1, mode: 1, sel: 4'd0, exp_out: 16'h0020, exp_idx: 4'd5,  exp_wrap: 0}; vecs.push_back(v);
    v = '{en: 1, mode: 1, sel: 4'd0, exp_out: 16'h0020, exp_idx: 4'd5,  exp_wrap: 0}; vecs.push_back(v);
    v = '{en: 1, mode: 1, sel: 4'd0, exp_out: 16'h0040, exp_idx: 4'd6,  exp_wrap: 0}; vecs.push_back(v);
    last4 = 15; dwell4 = 2;
    for (int i = 0; i < vecs.size(); i++) begin
      en4 = vecs[i].en; mode4 = vecs[i].mode; sel4 = vecs[i].sel;
      tick();
      check($sformatf("table%0d.out", i),  32'(out4),  32'(vecs[i].exp_out));
      check($sformatf("table%0d.idx", i),  32'(idx4),  32'(vecs[i].exp_idx));
      check($sformatf("table%0d.wrap", i), 32'(wrap4), 32'(vecs[i].exp_wrap));
    end

    // randomized traffic against the reference model
    en4 = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rand_reset.out", 32'(out4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last4 = 4'($urandom_range(0, 15));
    dwell4 = 4'($urandom_range(0, 3));
    for (int c = 0; c < 600; c++) begin
      en4   = ($urandom_range(0, 9) != 0);
      mode4 = ($urandom_range(0, 7) != 0);
      sel4  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) last4 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) dwell4 = 4'($urandom_range(0, 3));
      @(posedge clk);
      model_step(en4, mode4, int'(sel4), int'(last4), int'(dwell4));
      #1;
      check($sformatf("rand%0d.out", c),  32'(out4),  m_on ? 32'(1 << m_idx) : 32'd0);
      check($sformatf("rand%0d.idx", c),  32'(idx4),  32'(m_idx));
      check($sformatf("rand%0d.wrap", c), 32'(wrap4), 32'(m_wrap));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered one-hot decoder with an auto-scan mode. In direct mode it decodes a SEL_W-bit select into a 2**SEL_W-line one-hot output, registered, with enable gating. In scan mode an internal dwell counter steps the decoded line through indices 0..last and then wraps. The block drives multiplexed displays and row/column strobes, replacing hand-built cascaded 2-to-4 and 4-to-16 decoder trees.

## Interface
- SEL_W, 2, select/index width; number of output lines N = 2**SEL_W (legal 1..6)
- DWELL_W, 16, width of the dwell counter and `dwell` input
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  enable; when low, all outputs are blanked and state is frozen
- mode  in  1  0 = direct decode of `sel`; 1 = auto-scan
- sel  in  SEL_W  index decoded in direct mode
- last  in  SEL_W  highest index visited in scan mode; the sequence wraps after it
- dwell  in  DWELL_W  extra cycles each index is held in scan mode; each index is held for dwell+1 cycles
- out  out  N  one-hot decoded lines; out[i]=1 when the active index is i
- idx  out  SEL_W  current active index, coherent with `out`
- wrap  out  1  one-cycle pulse on the edge where scan wraps idx to 0

## Operation
- State registers: idx (SEL_W), cnt (DWELL_W), out (N), wrap (1), mode_q (1, previous mode).
- Reset (asynchronous, rst_n=0): out=0, idx=0, cnt=0, wrap=0, mode_q=0. All values hold until the first rising edge after rst_n rises.
- en=0: out<=0, wrap<=0. idx, cnt and mode_q hold. Re-enabling resumes from the held idx/cnt. out becomes onehot(idx) one edge later (scan) or onehot(sel) (direct).
- Direct mode (en=1, mode=0): idx<=sel, out<=onehot(sel), cnt<=0, wrap<=0.
- Scan entry (en=1, mode=1, mode_q=0): cnt<=0, idx holds, out<=onehot(idx), wrap<=0. This is the first cycle of dwell for the current index.
- Scan step (en=1, mode=1, mode_q=1):
  - cnt<dwell: cnt<=cnt+1; idx and out hold; wrap<=0.
  - cnt>=dwell: cnt<=0 and idx advances.
    - idx<last: idx<=idx+1, out<=onehot(idx+1), wrap<=0.
    - idx>=last: idx<=0, out<=onehot(0), wrap<=1. This also covers idx>last, e.g. after `last` is lowered mid-scan.
- last=0: the scan stays on index 0 and pulses wrap every dwell+1 cycles.
- dwell changed mid-scan: the comparison uses the live value. If cnt already exceeds the new dwell, the next edge advances.
- mode_q<=mode on every enabled edge.
- Invariant: out is either all-zero or exactly onehot(idx). No other pattern is legal.

## Timing
- All outputs are registered. Direct-mode latency is 1 cycle from sel to out/idx.
- Scan period per index = dwell+1 enabled cycles. Full sweep = (last+1)*(dwell+1) enabled cycles.
- wrap is high for exactly one cycle, coincident with the first cycle of out[0] after a wrap.
- Blanking latency: out=0 one edge after en falls. Unblanking latency: one edge after en rises.
- Arithmetic: idx+1 and cnt+1 never overflow their widths, because of the >=last and >=dwell tests.
- Reset asserted mid-scan clears all state immediately, without waiting for a clock edge.

## Test plan
- Reset/direct: SEL_W=2. Assert rst_n=0 mid-cycle; out=0000, idx=0, wrap=0 immediately. Release reset, set en=1, mode=0, sel=2; after 1 edge out[2]=1 only and idx=2.
- Exhaustive direct: SEL_W=4; sweep sel 0..15 with en=1. Each out is onehot(sel) one cycle later. With en=0, out=0 and idx holds.
- Scan wrap: SEL_W=2, dwell=3, last=3, start idx=0, mode 0->1. Index sequence is 0,1,2,3,0, each held 4 cycles. wrap pulses once, 16 cycles after scan entry.
- Short scan: last=1, dwell=0. out alternates 0001/0010 every cycle and wrap is high every 2nd cycle. Then lower last to 0 while idx=1: the next edge sets idx=0 with wrap=1.
- Freeze/resume: scanning, dwell=3, at idx=2 with cnt=1. Drop en for 5 cycles: out=0 and idx/cnt hold. Raise en: out[2]=1 for the remaining 2 cycles, then idx=3.
- Mode switch: scanning at idx=3, switch to direct with sel=1; the next edge gives idx=1. Switch back to scan: the scan restarts dwell at idx=1 with cnt=0.
